// File: rtl/gcd_host.sv
// Host-side sequencer for a nibble-serial GCD engine: sends eight operand nibbles, collects four result beats.
// Optional result-beat watchdog enabled by defining GCD_HOST_TIMEOUT_EN (limit set by TIMEOUT_CYC).
module gcd_host #(
   parameter int TIMEOUT_CYC = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_data,
   output logic        in_valid,
   output logic [3:0]  in_data,
   input  logic        out_valid,
   input  logic [4:0]  out_data,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [4:0]  rsp_sum0,
   output logic [4:0]  rsp_sum1,
   output logic [4:0]  rsp_sum2,
   output logic [4:0]  rsp_gcd,
   output logic        rsp_timeout
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SEND    = 3'd1,
      WAIT    = 3'd2,
      COLLECT = 3'd3,
      RESP    = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic        ready_q, ready_d;
   logic [31:0] data_q, data_d;
   logic [2:0]  idx_q, idx_d;
   logic [1:0]  beat_q, beat_d;
   logic [4:0]  sum0_q, sum0_d;
   logic [4:0]  sum1_q, sum1_d;
   logic [4:0]  sum2_q, sum2_d;
   logic [4:0]  gcd_q, gcd_d;

`ifdef GCD_HOST_TIMEOUT_EN
   localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
   logic [TMR_W-1:0] timer_q, timer_d, timer_inc;
   logic             timeout_q, timeout_d;
`else
   logic unused_cfg;
   assign unused_cfg = (TIMEOUT_CYC == 0);
`endif

   // req_ready is its own flop so it stays low while rst_n is held, even though state is IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ready_q   <= 1'b0;
         data_q    <= '0;
         idx_q     <= '0;
         beat_q    <= '0;
         sum0_q    <= '0;
         sum1_q    <= '0;
         sum2_q    <= '0;
         gcd_q     <= '0;
`ifdef GCD_HOST_TIMEOUT_EN
         timer_q   <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         ready_q   <= ready_d;
         data_q    <= data_d;
         idx_q     <= idx_d;
         beat_q    <= beat_d;
         sum0_q    <= sum0_d;
         sum1_q    <= sum1_d;
         sum2_q    <= sum2_d;
         gcd_q     <= gcd_d;
`ifdef GCD_HOST_TIMEOUT_EN
         timer_q   <= timer_d;
         timeout_q <= timeout_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      idx_d   = idx_q;
      beat_d  = beat_q;
      sum0_d  = sum0_q;
      sum1_d  = sum1_q;
      sum2_d  = sum2_q;
      gcd_d   = gcd_q;
`ifdef GCD_HOST_TIMEOUT_EN
      timer_d   = timer_q;
      timeout_d = timeout_q;
      timer_inc = timer_q + TMR_W'(1);
`endif
      case (state_q)
         IDLE: begin
            if (req_valid && ready_q) begin
               state_d = SEND;
               data_d  = req_data;
               idx_d   = '0;
               beat_d  = '0;
               sum0_d  = '0;
               sum1_d  = '0;
               sum2_d  = '0;
               gcd_d   = '0;
`ifdef GCD_HOST_TIMEOUT_EN
               timer_d   = '0;
               timeout_d = 1'b0;
`endif
            end
         end
         SEND: begin
            idx_d = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (out_valid) begin
               sum0_d  = out_data;
               beat_d  = 2'd1;
               state_d = COLLECT;
            end
         end
         COLLECT: begin
            if (out_valid) begin
               case (beat_q)
                  2'd1:    sum1_d = out_data;
                  2'd2:    sum2_d = out_data;
                  default: gcd_d  = out_data;
               endcase
               // Saturate at the last beat rather than wrapping the 2-bit count.
               if (beat_q == 2'd3) begin
                  state_d = RESP;
               end else begin
                  beat_d = beat_q + 2'd1;
               end
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
`ifdef GCD_HOST_TIMEOUT_EN
      // Watchdog counts only silent cycles; any beat restarts it.
      if (state_q == WAIT || state_q == COLLECT) begin
         if (out_valid) begin
            timer_d = '0;
         end else if (timer_inc == TMR_W'(TIMEOUT_CYC)) begin
            state_d   = RESP;
            timeout_d = 1'b1;
         end else begin
            timer_d = timer_inc;
         end
      end
`endif
      ready_d = (state_d == IDLE);
   end

   always_comb begin
      req_ready = ready_q;
      in_valid  = (state_q == SEND);
      in_data   = 4'd0;
      if (state_q == SEND) begin
         in_data = data_q[{idx_q, 2'b00} +: 4];
      end
      rsp_valid = (state_q == RESP);
      rsp_sum0  = sum0_q;
      rsp_sum1  = sum1_q;
      rsp_sum2  = sum2_q;
      rsp_gcd   = gcd_q;
`ifdef GCD_HOST_TIMEOUT_EN
      rsp_timeout = timeout_q;
`else
      rsp_timeout = 1'b0;
`endif
   end

endmodule

// File: tb/tb_gcd_host.sv
// Self-checking bench for gcd_host: table vectors, random requests against an engine model, reset and timeout sequences.
module tb_gcd_host;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_data = '0;
   logic        in_valid;
   logic [3:0]  in_data;
   logic        out_valid = 1'b0;
   logic [4:0]  out_data = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [4:0]  rsp_sum0, rsp_sum1, rsp_sum2, rsp_gcd;
   logic        rsp_timeout;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   gcd_host #(.TIMEOUT_CYC(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
      .in_valid(in_valid), .in_data(in_data),
      .out_valid(out_valid), .out_data(out_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_sum0(rsp_sum0), .rsp_sum1(rsp_sum1), .rsp_sum2(rsp_sum2), .rsp_gcd(rsp_gcd),
      .rsp_timeout(rsp_timeout)
   );

   typedef struct {
      logic [31:0]     req;
      logic [3:0][4:0] beats;
      int              gap;
      bit              spurious;
      int              hold;
      logic [3:0][4:0] exp;
   } vec_t;

   vec_t vecs[4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic int gcd_i(input int a, input int b);
      int x = a;
      int y = b;
      int t;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   // Engine behaviour: pairwise sums of nibbles 0..5, then the gcd of those three sums.
   function automatic logic [3:0][4:0] engine(input logic [31:0] r);
      logic [3:0][4:0] b;
      int s0, s1, s2;
      s0 = int'(r[3:0]) + int'(r[7:4]);
      s1 = int'(r[11:8]) + int'(r[15:12]);
      s2 = int'(r[19:16]) + int'(r[23:20]);
      b[0] = 5'(s0);
      b[1] = 5'(s1);
      b[2] = 5'(s2);
      b[3] = 5'(gcd_i(gcd_i(s0, s1), s2));
      return b;
   endfunction

   task automatic wait_ready;
      int n = 0;
      while (!req_ready && n < 20) begin
         tick();
         n++;
      end
      check("req_ready_wait", 32'(req_ready), 32'd1);
   endtask

   // Handshake a request and watch the full nibble burst.
   task automatic send_req(input logic [31:0] r, input bit spurious);
      logic [31:0] tmp;
      wait_ready();
      req_valid = 1'b1;
      req_data  = r;
      tick();
      req_valid = 1'b0;
      check("fields_cleared", 32'({rsp_sum0, rsp_sum1, rsp_sum2, rsp_gcd, rsp_timeout}), 32'd0);
      check("req_ready_send", 32'(req_ready), 32'd0);
      tmp = r;
      for (int i = 0; i < 8; i++) begin
         check("in_valid_send", 32'(in_valid), 32'd1);
         check("in_data_nibble", 32'(in_data), 32'(tmp[3:0]));
         tmp = tmp >> 4;
         out_valid = spurious && (i == 3);
         out_data  = 5'd31;
         tick();
      end
      out_valid = 1'b0;
      out_data  = '0;
      check("in_valid_after", 32'(in_valid), 32'd0);
      check("in_data_idle", 32'(in_data), 32'd0);
   endtask

   task automatic beat(input logic [4:0] v, input int gap);
      for (int g = 0; g < gap; g++) begin
         check("no_early_rsp", 32'(rsp_valid), 32'd0);
         tick();
      end
      out_valid = 1'b1;
      out_data  = v;
      tick();
      out_valid = 1'b0;
      out_data  = '0;
   endtask

   task automatic check_rsp(input logic [3:0][4:0] exp, input logic tmo);
      check("rsp_valid", 32'(rsp_valid), 32'd1);
      check("rsp_sum0", 32'(rsp_sum0), 32'(exp[0]));
      check("rsp_sum1", 32'(rsp_sum1), 32'(exp[1]));
      check("rsp_sum2", 32'(rsp_sum2), 32'(exp[2]));
      check("rsp_gcd", 32'(rsp_gcd), 32'(exp[3]));
      check("rsp_timeout", 32'(rsp_timeout), 32'(tmo));
   endtask

   task automatic finish_rsp(input logic [3:0][4:0] exp, input int hold);
      for (int h = 0; h < hold; h++) begin
         req_valid = 1'b1;
         req_data  = 32'hDEADBEEF;
         tick();
         check("bp_req_ready", 32'(req_ready), 32'd0);
         check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
         check("bp_fields", 32'({rsp_sum0, rsp_sum1, rsp_sum2, rsp_gcd}), 32'({exp[0], exp[1], exp[2], exp[3]}));
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("rsp_done_valid", 32'(rsp_valid), 32'd0);
      check("rsp_done_ready", 32'(req_ready), 32'd1);
      check("idle_hold_gcd", 32'(rsp_gcd), 32'(exp[3]));
   endtask

   task automatic run_vec(input vec_t v);
      send_req(v.req, v.spurious);
      for (int b = 0; b < 4; b++) beat(v.beats[b], v.gap);
      check_rsp(v.exp, 1'b0);
      finish_rsp(v.exp, v.hold);
      $display("txn req=%08h gap=%0d spur=%0d -> %0d %0d %0d %0d", v.req, v.gap, v.spurious,
               rsp_sum0, rsp_sum1, rsp_sum2, rsp_gcd);
   endtask

   initial begin
      vec_t v;
      int n;

      vecs[0].req = 32'h71865342; vecs[0].beats = engine(32'h71865342);
      vecs[0].gap = 0; vecs[0].spurious = 0; vecs[0].hold = 10;
      vecs[0].exp[0] = 5'd6; vecs[0].exp[1] = 5'd8; vecs[0].exp[2] = 5'd14; vecs[0].exp[3] = 5'd2;

      vecs[1].req = 32'h12345678;
      vecs[1].beats[0] = 5'd9; vecs[1].beats[1] = 5'd12; vecs[1].beats[2] = 5'd15; vecs[1].beats[3] = 5'd3;
      vecs[1].gap = 3; vecs[1].spurious = 0; vecs[1].hold = 1;
      vecs[1].exp[0] = 5'd9; vecs[1].exp[1] = 5'd12; vecs[1].exp[2] = 5'd15; vecs[1].exp[3] = 5'd3;

      vecs[2].req = 32'hFFFF0000; vecs[2].beats = engine(32'hFFFF0000);
      vecs[2].gap = 0; vecs[2].spurious = 1; vecs[2].hold = 0;
      vecs[2].exp[0] = 5'd0; vecs[2].exp[1] = 5'd0; vecs[2].exp[2] = 5'd30; vecs[2].exp[3] = 5'd30;

      vecs[3].req = 32'hFFFFFFFF; vecs[3].beats = engine(32'hFFFFFFFF);
      vecs[3].gap = 1; vecs[3].spurious = 1; vecs[3].hold = 2;
      vecs[3].exp[0] = 5'd30; vecs[3].exp[1] = 5'd30; vecs[3].exp[2] = 5'd30; vecs[3].exp[3] = 5'd30;

      // Reset state
      tick(); tick();
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_in_valid", 32'(in_valid), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_fields", 32'({rsp_sum0, rsp_sum1, rsp_sum2, rsp_gcd, rsp_timeout}), 32'd0);
      rst_n = 1'b1;
      tick();
      check("rel_req_ready", 32'(req_ready), 32'd1);

      for (int i = 0; i < 4; i++) run_vec(vecs[i]);

      // Reset in the middle of the operand burst
      wait_ready();
      req_valid = 1'b1;
      req_data  = 32'hA5C3E1F7;
      tick();
      req_valid = 1'b0;
      repeat (4) tick();
      check("pre_rst_nib4", 32'(in_data), 32'h3);
      rst_n = 1'b0;
      #1;
      check("async_in_valid", 32'(in_valid), 32'd0);
      check("async_in_data", 32'(in_data), 32'd0);
      check("async_req_ready", 32'(req_ready), 32'd0);
      tick(); tick();
      check("rst_hold_in_valid", 32'(in_valid), 32'd0);
      rst_n = 1'b1;
      check("pre_edge_ready", 32'(req_ready), 32'd0);
      tick();
      check("post_rst_ready", 32'(req_ready), 32'd1);
      check("post_rst_in_valid", 32'(in_valid), 32'd0);
      $display("txn reset mid-burst");
      run_vec(vecs[0]);

`ifdef GCD_HOST_TIMEOUT_EN
      send_req(32'h00112233, 1'b0);
      beat(5'd5, 0);
      beat(5'd10, 0);
      n = 0;
      while (!rsp_valid && n < 40) begin
         tick();
         n++;
      end
      check("timeout_cycles", 32'(n), 32'd16);
      v.exp[0] = 5'd5; v.exp[1] = 5'd10; v.exp[2] = 5'd0; v.exp[3] = 5'd0;
      check_rsp(v.exp, 1'b1);
      finish_rsp(v.exp, 1);
      $display("txn timeout after %0d idle cycles", n);
`else
      // Without the watchdog a stalled engine is waited on indefinitely.
      send_req(32'h00112233, 1'b0);
      beat(5'd5, 0);
      beat(5'd10, 0);
      n = 0;
      repeat (80) begin
         tick();
         if (rsp_valid) n++;
      end
      check("no_timeout_rsp", 32'(n), 32'd0);
      beat(5'd7, 0);
      beat(5'd1, 0);
      v.exp[0] = 5'd5; v.exp[1] = 5'd10; v.exp[2] = 5'd7; v.exp[3] = 5'd1;
      check_rsp(v.exp, 1'b0);
      finish_rsp(v.exp, 0);
      $display("txn stalled engine completes late");
`endif

      // Random requests against the engine model; the host must relay beats verbatim.
      for (int i = 0; i < 12; i++) begin
         v.req      = $urandom;
         v.beats    = engine(v.req);
         v.gap      = int'($urandom_range(0, 3));
         v.spurious = 1'($urandom_range(0, 1));
         v.hold     = int'($urandom_range(0, 3));
         v.exp      = v.beats;
         run_vec(v);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
